// File: rtl/ldl_arb_pkg.sv
// Shared types and helpers for the ldl arbiter family.
package ldl_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Modulo-n increment with an explicit wrap, so n need not be a power of two.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Rotating-priority encoder: first set request at or above i_ptr, wrapping at N.
module ldl_rr_pick
  import ldl_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [31:0] w_j;

  // Walk the ring from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_idx = '0;
    w_j   = 32'd0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j   = 32'(i_ptr) + 32'(k);
      w_j   = (w_j >= 32'(N)) ? (w_j - 32'(N)) : w_j;
      o_idx = i_req[w_j[IW-1:0]] ? w_j[IW-1:0] : o_idx;
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/ldl_sfifo_wr_arb.sv
// Round-robin packet-locking arbiter for the single write port of a sync FIFO.
module ldl_sfifo_wr_arb
  import ldl_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int MAXLEN = 64,
  parameter int IW     = $clog2(N),
  parameter int CW     = $clog2(MAXLEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_last,
  input  logic          i_full,
  output logic [N-1:0]  o_gnt,
  output logic          o_we,
  output logic [IW-1:0] o_sel,
  output logic          o_busy,
  output logic          o_trunc
);

  arb_state_t    r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_trunc;

  logic [IW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic          w_beat;
  logic          w_last;
  logic          w_max;
  logic          w_rel;

  ldl_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Grant depends only on state, owner, owner's req and full; last only steers release.
  assign w_beat = (r_state == LOCK) & i_req[r_owner] & ~i_full;
  assign w_last = i_last[r_owner];
  assign w_max  = ((r_cnt + CW'(1)) == CW'(MAXLEN));
  assign w_rel  = w_beat & (w_last | w_max);

  always_comb begin
    o_gnt          = '0;
    o_gnt[r_owner] = w_beat;
  end

  assign o_we    = w_beat;
  assign o_sel   = r_owner;
  assign o_busy  = (r_state == LOCK);
  assign o_trunc = r_trunc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_trunc <= 1'b0;
          if (w_pick_any) begin
            r_owner <= w_pick_idx;
            r_cnt   <= '0;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          // Truncation flag only when the length limit alone ends the tenure.
          r_trunc <= w_beat & w_max & ~w_last;
          if (w_beat) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_rel) begin
            r_state <= IDLE;
            r_ptr   <= IW'(rr_next(32'(r_owner), 32'(N)));
          end
        end
        default: begin
          r_state <= IDLE;
          r_trunc <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldl_sfifo_wr_arb.sv
// Bench for ldl_sfifo_wr_arb: directed vector table, an N=3 wrap sequence, and random vs a reference model.
module tb_ldl_sfifo_wr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req4, last4, gnt4;
  logic       full4, we4, busy4, trunc4;
  logic [1:0] sel4;
  logic [2:0] req3, last3, gnt3;
  logic       full3, we3, busy3, trunc3;
  logic [1:0] sel3;

  int n_vec = 0;
  int n_err = 0;

  bit m_lock[2];
  bit m_trunc[2];
  int m_owner[2];
  int m_ptr[2];
  int m_cnt[2];

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic       rst;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       trunc;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  ldl_sfifo_wr_arb #(.N(4), .MAXLEN(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req4), .i_last(last4), .i_full(full4),
    .o_gnt(gnt4), .o_we(we4), .o_sel(sel4), .o_busy(busy4), .o_trunc(trunc4)
  );

  ldl_sfifo_wr_arb #(.N(3), .MAXLEN(64)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_req(req3), .i_last(last3), .i_full(full3),
    .o_gnt(gnt3), .o_we(we3), .o_sel(sel3), .o_busy(busy3), .o_trunc(trunc3)
  );

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] ls, input logic fl,
                              input logic rs, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
    vec_t v;
    v.req = rq; v.last = ls; v.full = fl; v.rst = rs;
    v.gnt = g;  v.sel = s;   v.busy = b;  v.trunc = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] ag, input logic [15:0] eg,
                     input logic aw, input logic [3:0] as, input logic [3:0] es,
                     input logic ab, input logic eb, input logic at, input logic et);
    n_vec++;
    if (ag !== eg || aw !== (|eg) || as !== es || ab !== eb || at !== et) begin
      n_err++;
      $display("FAIL %s: got gnt=%h we=%b sel=%0d busy=%b trunc=%b, want gnt=%h we=%b sel=%0d busy=%b trunc=%b",
               name, ag, aw, as, ab, at, eg, |eg, es, eb, et);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lock[d] = 1'b0; m_trunc[d] = 1'b0;
      m_owner[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic model_check(input int d, input logic [15:0] rq, input logic fl,
                             input logic [15:0] ag, input logic aw, input logic [3:0] as,
                             input logic ab, input logic at);
    logic [15:0] eg;
    eg = 16'h0;
    if (m_lock[d] && rq[m_owner[d]] && !fl) eg[m_owner[d]] = 1'b1;
    chk($sformatf("rand_dut%0d", d), ag, eg, aw, as, 4'(m_owner[d]), ab, m_lock[d], at, m_trunc[d]);
  endtask

  // Arbiter rules stated directly: owner holds the port until a last beat or the length limit.
  task automatic model_step(input int d, input int n, input int maxlen, input logic [15:0] rq,
                            input logic [15:0] ls, input logic fl, input logic rs);
    if (rs) begin
      m_lock[d] = 1'b0; m_trunc[d] = 1'b0;
      m_owner[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
    end else if (!m_lock[d]) begin
      m_trunc[d] = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (rq[(m_ptr[d] + k) % n]) begin
          m_owner[d] = (m_ptr[d] + k) % n;
          m_lock[d]  = 1'b1;
          m_cnt[d]   = 0;
          break;
        end
      end
    end else begin
      m_trunc[d] = 1'b0;
      if (rq[m_owner[d]] && !fl) begin
        m_cnt[d]++;
        if (ls[m_owner[d]] || m_cnt[d] == maxlen) begin
          m_trunc[d] = !ls[m_owner[d]];
          m_lock[d]  = 1'b0;
          m_ptr[d]   = (m_owner[d] + 1) % n;
        end
      end
    end
  endtask

  task automatic step3(input logic [2:0] rq, input logic [2:0] ls, input logic [2:0] eg,
                       input logic [1:0] es, input logic eb, input string name);
    req3 = rq; last3 = ls; full3 = 1'b0;
    @(negedge clk);
    chk(name, {13'h0, gnt3}, {13'h0, eg}, we3, {2'b00, sel3}, {2'b00, es}, busy3, eb, trunc3, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req4 = 4'h0; last4 = 4'h0; full4 = 1'b0;
    req3 = 3'h0; last3 = 3'h0; full3 = 1'b0;

    // N=4, MAXLEN=4 directed scenarios, continuous from reset.
    tbl.push_back(mk(4'h5, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h5, 4'hF, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h5, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h5, 4'hF, 1'b0, 1'b0, 4'h4, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'h5, 4'hF, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 1'b0));
    tbl.push_back(mk(4'h5, 4'hF, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(4'hA, 4'h0, 1'b0, 1'b0, 4'h2, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(4'hA, 4'h2, 1'b0, 1'b0, 4'h2, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(4'h8, 4'h8, 1'b0, 1'b0, 4'h0, 2'd1, 1'b0, 1'b0));
    tbl.push_back(mk(4'h8, 4'h8, 1'b0, 1'b0, 4'h8, 2'd3, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd3, 1'b0, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1));
    tbl.push_back(mk(4'h3, 4'h2, 1'b0, 1'b0, 4'h2, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd1, 1'b0, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'h4, 4'h0, 1'b0, 1'b1, 4'h4, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h5, 4'h1, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_dut4", {12'h0, gnt4}, 16'h0, we4, {2'b00, sel4}, 4'd0, busy4, 1'b0, trunc4, 1'b0);
    chk("reset_dut3", {13'h0, gnt3}, 16'h0, we3, {2'b00, sel3}, 4'd0, busy3, 1'b0, trunc3, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      req4 = tbl[i].req; last4 = tbl[i].last; full4 = tbl[i].full; rst = tbl[i].rst;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {12'h0, gnt4}, {12'h0, tbl[i].gnt}, we4, {2'b00, sel4},
          {2'b00, tbl[i].sel}, busy4, tbl[i].busy, trunc4, tbl[i].trunc);
      @(posedge clk); #1;
    end
    rst = 1'b0; req4 = 4'h0; last4 = 4'h0; full4 = 1'b0;

    // N=3: releasing requester 2 wraps the pointer to 0, so 0 beats 1.
    step3(3'b100, 3'b100, 3'b000, 2'd0, 1'b0, "n3_idle0");
    step3(3'b100, 3'b100, 3'b100, 2'd2, 1'b1, "n3_gnt2");
    step3(3'b011, 3'b011, 3'b000, 2'd2, 1'b0, "n3_idle1");
    step3(3'b011, 3'b011, 3'b001, 2'd0, 1'b1, "n3_wrap_gnt0");
    step3(3'b011, 3'b011, 3'b000, 2'd0, 1'b0, "n3_idle2");
    step3(3'b011, 3'b011, 3'b010, 2'd1, 1'b1, "n3_gnt1");
    req3 = 3'h0; last3 = 3'h0;

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    for (int c = 0; c < 800; c++) begin
      req4  = 4'($urandom);
      full4 = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++) last4[b] = ($urandom_range(0, 3) == 0);
      req3  = 3'($urandom);
      full3 = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < 3; b++) last3[b] = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 79) == 0);
      @(negedge clk);
      model_check(0, {12'h0, req4}, full4, {12'h0, gnt4}, we4, {2'b00, sel4}, busy4, trunc4);
      model_check(1, {13'h0, req3}, full3, {13'h0, gnt3}, we3, {2'b00, sel3}, busy3, trunc3);
      model_step(0, 4, 4,  {12'h0, req4}, {12'h0, last4}, full4, rst);
      model_step(1, 3, 64, {13'h0, req3}, {13'h0, last3}, full3, rst);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
